// File: rtl/mm_pkg.sv
// Shared definitions for the constant 2x2 multiplier and its result collector:
// default widths, output FSM encoding and the round/saturate helper.
package mm_pkg;

    localparam int MM_IN_W  = 27;
    localparam int MM_OUT_W = 16;
    localparam int MM_LAT   = 8;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SEND_Y = 2'd1,
        SEND_Z = 2'd2
    } out_state_e;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] value;
    } round_sat_t;

    // Round-half-up then clamp to a signed out_w range. Working in 64 bits
    // keeps the rounding add from wrapping for any input up to ~62 bits.
    function automatic round_sat_t round_sat(input logic signed [63:0] value,
                                             input int shift,
                                             input int out_w);
        logic signed [63:0] v;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        round_sat_t         r;
        v = value;
        if (shift > 0) begin
            v = (v + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        max_v   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (out_w - 1));
        r.sat   = 1'b0;
        r.value = v;
        if (v > max_v) begin
            r.sat   = 1'b1;
            r.value = max_v;
        end else if (v < min_v) begin
            r.sat   = 1'b1;
            r.value = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_result_collector_if.sv
// Multiplier-result input bus and serial word output stream of the collector.
// Output stream: a word transfers on a cycle where out_valid and out_ready are
// both high; while out_valid=1 and out_ready=0, out_data/out_is_z hold steady
// and out_valid stays high.
interface mm_result_collector_if #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic [IN_W-1:0]  y_in;
    logic [IN_W-1:0]  z_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_is_z;

    modport slave (
        input  in_valid, y_in, z_in, out_ready,
        output out_valid, out_data, out_is_z
    );

    modport master (
        output in_valid, y_in, z_in, out_ready,
        input  out_valid, out_data, out_is_z
    );
endinterface

// File: rtl/mm_pair_fifo.sv
// DEPTH-entry FIFO of packed {Y,Z} word pairs; exposes the head and the entry
// behind it so the reader can move straight to the next pair after a pop.
module mm_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [W-1:0]             next_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign next_data = mem_q[AW'(rd_ptr_q + 1'b1)];
    assign full      = (level_q == (AW+1)'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;

endmodule

// File: rtl/mm_result_collector.sv
// Tracks in_valid through a delay line matching the multiplier pipeline,
// captures/rounds/saturates Y/Z, buffers pairs and streams them out as Y,Z words.
module mm_result_collector
    import mm_pkg::*;
#(
    parameter int IN_W  = MM_IN_W,
    parameter int OUT_W = MM_OUT_W,
    parameter int SHIFT = 4,
    parameter int LAT   = MM_LAT,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mm_result_collector_if.slave   bus,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   sat_flag,
    output out_state_e             dbg_state
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = 2 * OUT_W;

    logic [LAT-1:0] dl_q, dl_d;
    logic           cap;

    always_comb begin
        dl_d    = dl_q << 1;
        dl_d[0] = bus.in_valid;
    end
    assign cap = dl_q[LAT-1];

    logic signed [63:0] y_ext, z_ext;
    round_sat_t         rs_y, rs_z;
    logic [OUT_W-1:0]   y_word, z_word;

    always_comb begin
        y_ext  = 64'(signed'(bus.y_in));
        z_ext  = 64'(signed'(bus.z_in));
        rs_y   = round_sat(y_ext, SHIFT, OUT_W);
        rs_z   = round_sat(z_ext, SHIFT, OUT_W);
        y_word = rs_y.value[OUT_W-1:0];
        z_word = rs_z.value[OUT_W-1:0];
    end

    logic [PW-1:0] fifo_head, fifo_next;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          push, pop, drop;

    out_state_e       state_q;
    logic             out_valid_q;
    logic             out_is_z_q;
    logic [OUT_W-1:0] out_data_q;

    // A full FIFO still accepts a capture when the head pair leaves this cycle.
    assign pop  = (state_q == SEND_Z) && bus.out_ready;
    assign push = cap && (!fifo_full || pop);
    assign drop = cap && fifo_full && !pop;

    mm_pair_fifo #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({y_word, z_word}),
        .pop       (pop),
        .head_data (fifo_head),
        .next_data (fifo_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    logic             more_after_pop;
    logic [OUT_W-1:0] after_y;

    // The pair following the head is either already stored or is the one
    // being pushed in this very cycle.
    always_comb begin
        more_after_pop = (fifo_level > LW'(1)) || push;
        after_y        = (fifo_level > LW'(1)) ? fifo_next[PW-1:OUT_W] : y_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_is_z_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (!fifo_empty) begin
                        state_q     <= SEND_Y;
                        out_valid_q <= 1'b1;
                        out_is_z_q  <= 1'b0;
                        out_data_q  <= fifo_head[PW-1:OUT_W];
                    end
                end
                SEND_Y: begin
                    if (bus.out_ready) begin
                        state_q    <= SEND_Z;
                        out_is_z_q <= 1'b1;
                        out_data_q <= fifo_head[OUT_W-1:0];
                    end
                end
                SEND_Z: begin
                    if (bus.out_ready) begin
                        out_is_z_q <= 1'b0;
                        if (more_after_pop) begin
                            state_q    <= SEND_Y;
                            out_data_q <= after_y;
                        end else begin
                            state_q     <= EMPTY;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    out_is_z_q  <= 1'b0;
                end
            endcase
        end
    end

    logic overflow_q, overflow_d;
    logic sat_q, sat_d;

    // Set events take priority over a same-cycle clear.
    always_comb begin
        overflow_d = clear ? 1'b0 : overflow_q;
        sat_d      = clear ? 1'b0 : sat_q;
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (cap && (rs_y.sat || rs_z.sat)) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            dl_q       <= dl_d;
            overflow_q <= overflow_d;
            sat_q      <= sat_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_is_z  = out_is_z_q;
    assign bus.out_data  = out_data_q;
    assign level         = fifo_level;
    assign overflow      = overflow_q;
    assign sat_flag      = sat_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector: latency, saturation, backpressure,
// overflow, rounding edges (SHIFT=4 and SHIFT=0) and asynchronous reset.
module tb_mm_result_collector;
    import mm_pkg::*;

    localparam int IN_W  = 27;
    localparam int OUT_W = 16;
    localparam int LAT   = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [IN_W-1:0] JUNK = IN_W'(12345);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          clear0 = 1'b0;
    logic [LW-1:0] level, level0;
    logic          overflow, overflow0;
    logic          sat_flag, sat_flag0;
    out_state_e    dbg_state, dbg_state0;

    int n_tests = 0;
    int n_fail  = 0;

    mm_result_collector_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b ();
    mm_result_collector_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b0 ();

    mm_result_collector #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(4), .LAT(LAT), .DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(b), .clear(clear),
        .level(level), .overflow(overflow), .sat_flag(sat_flag), .dbg_state(dbg_state)
    );

    mm_result_collector #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(0), .LAT(LAT), .DEPTH(DEPTH)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .clear(clear0),
        .level(level0), .overflow(overflow0), .sat_flag(sat_flag0), .dbg_state(dbg_state0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w16(input int v);
        return {16'h0, 16'(v)};
    endfunction

    function automatic logic [31:0] dout();
        return {16'h0, b.out_data};
    endfunction

    // Launch a token now and present y/z exactly in the cap cycle; returns one
    // cycle after the capture edge.
    task automatic capture(input int y, input int z);
        b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
        repeat (LAT - 1) tick();
        b.y_in = IN_W'(y);
        b.z_in = IN_W'(z);
        tick();
        b.y_in = JUNK;
        b.z_in = JUNK;
    endtask

    task automatic cap_read(input int y, input int z, input int ey, input int ez, input string tag);
        capture(y, z);
        tick();
        check({tag, "_y"}, dout(), w16(ey));
        check({tag, "_yz"}, 32'(b.out_is_z), 32'(0));
        tick();
        check({tag, "_z"}, dout(), w16(ez));
        check({tag, "_zz"}, 32'(b.out_is_z), 32'(1));
        tick();
        check({tag, "_idle"}, 32'(b.out_valid), 32'(0));
    endtask

    int exp_w[8] = '{2, -2, 3, -3, 4, -4, 6, -6};

    initial begin
        b.in_valid = 1'b0;  b.y_in = JUNK;  b.z_in = JUNK;  b.out_ready = 1'b0;
        b0.in_valid = 1'b0; b0.y_in = JUNK; b0.z_in = JUNK; b0.out_ready = 1'b0;

        #12;
        check("rst_valid", 32'(b.out_valid), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_sat", 32'(sat_flag), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(EMPTY));
        #2 rst_n = 1'b1;
        tick();

        // Latency: token launched in cycle 0 must capture only in cycle 8.
        b.out_ready = 1'b1;
        b.in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            b.in_valid = 1'b0;
            check("t1_nocap", 32'(level), 32'(0));
            if (i == 8) begin
                b.y_in = IN_W'(-35);
                b.z_in = IN_W'(130);
            end
        end
        tick();
        b.y_in = JUNK;
        b.z_in = JUNK;
        check("t1_level1", 32'(level), 32'(1));
        check("t1_nobypass", 32'(b.out_valid), 32'(0));
        tick();
        check("t1_valid", 32'(b.out_valid), 32'(1));
        check("t1_y", dout(), w16(-2));
        check("t1_yz", 32'(b.out_is_z), 32'(0));
        tick();
        check("t1_z", dout(), w16(8));
        check("t1_zz", 32'(b.out_is_z), 32'(1));
        tick();
        check("t1_idle", 32'(b.out_valid), 32'(0));
        check("t1_level0", 32'(level), 32'(0));

        // Saturation and flag clear.
        check("t2_sat_pre", 32'(sat_flag), 32'(0));
        capture(1000000, -1000000);
        tick();
        check("t2_ymax", dout(), w16(32767));
        tick();
        check("t2_zmin", dout(), w16(-32768));
        check("t2_sat", 32'(sat_flag), 32'(1));
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t2_sat_clr", 32'(sat_flag), 32'(0));

        // Backpressure: two pairs held, then drained back to back.
        b.out_ready = 1'b0;
        capture(160, -160);
        capture(320, 48);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(b.out_valid), 32'(1));
            check("t3_hold_y0", dout(), w16(10));
            check("t3_hold_isz", 32'(b.out_is_z), 32'(0));
            check("t3_hold_level", 32'(level), 32'(2));
            tick();
        end
        b.out_ready = 1'b1;
        check("t3_y0", dout(), w16(10));
        tick();
        check("t3_z0", dout(), w16(-10));
        tick();
        check("t3_y1", dout(), w16(20));
        check("t3_level1", 32'(level), 32'(1));
        tick();
        check("t3_z1", dout(), w16(3));
        tick();
        check("t3_idle", 32'(b.out_valid), 32'(0));
        check("t3_level0", 32'(level), 32'(0));

        // Overflow: the fifth pair is dropped.
        b.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            capture(16 * i, -16 * i);
            if (i == 4) begin
                check("t4_full_level", 32'(level), 32'(4));
                check("t4_no_ovf", 32'(overflow), 32'(0));
            end
        end
        check("t4_level", 32'(level), 32'(4));
        check("t4_ovf", 32'(overflow), 32'(1));
        check("t4_head", dout(), w16(1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'(0));

        // Capture lands on the same cycle the full FIFO pops its head pair.
        b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
        repeat (6) tick();
        b.out_ready = 1'b1;
        tick();
        b.y_in = IN_W'(96);
        b.z_in = IN_W'(-96);
        check("t4_popz", dout(), w16(-1));
        check("t4_popz_isz", 32'(b.out_is_z), 32'(1));
        tick();
        b.out_ready = 1'b0;
        b.y_in = JUNK;
        b.z_in = JUNK;
        check("t4_pp_level", 32'(level), 32'(4));
        check("t4_pp_ovf", 32'(overflow), 32'(0));
        b.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t4_drain_data", dout(), w16(exp_w[i]));
            check("t4_drain_isz", 32'(b.out_is_z), 32'(i % 2));
            check("t4_drain_valid", 32'(b.out_valid), 32'(1));
            tick();
        end
        check("t4_idle", 32'(b.out_valid), 32'(0));
        check("t4_level0", 32'(level), 32'(0));

        // Rounding boundaries with SHIFT=4.
        cap_read(8, 7, 1, 0, "t5_pos");
        cap_read(-8, -9, 0, -1, "t5_neg");

        // SHIFT=0 instance: no rounding, saturation still applies.
        b0.out_ready = 1'b1;
        b0.in_valid  = 1'b1;
        tick();
        b0.in_valid = 1'b0;
        repeat (LAT - 1) tick();
        b0.y_in = IN_W'(-35);
        b0.z_in = IN_W'(100000);
        tick();
        b0.y_in = JUNK;
        b0.z_in = JUNK;
        tick();
        check("t5_s0_y", {16'h0, b0.out_data}, w16(-35));
        tick();
        check("t5_s0_z", {16'h0, b0.out_data}, w16(32767));
        check("t5_s0_sat", 32'(sat_flag0), 32'(1));

        // Asynchronous reset in SEND_Z with 3 stored pairs and 2 tokens in flight.
        b.out_ready = 1'b0;
        capture(100, 200);
        capture(300, 400);
        capture(500, 600);
        b.in_valid = 1'b1;
        tick();
        tick();
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        tick();
        b.out_ready = 1'b0;
        check("t6_in_sendz", 32'(b.out_is_z), 32'(1));
        check("t6_pre_level", 32'(level), 32'(3));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(b.out_valid), 32'(0));
        check("t6_rst_level", 32'(level), 32'(0));
        check("t6_rst_state", 32'(dbg_state), 32'(EMPTY));
        @(posedge clk);
        #3 rst_n = 1'b1;
        b.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t6_post_valid", 32'(b.out_valid), 32'(0));
            check("t6_post_level", 32'(level), 32'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
